// File: rtl/irrigacao_multizona.sv
// Multi-zone irrigation controller: debounced tank sensors, inlet-valve hysteresis
// and a round-robin scheduler that waters one zone at a time from a shared tank.
module irrigacao_multizona #(
    parameter int ZONAS           = 4,
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int TEMPO_REGA      = 16,
    parameter int PAUSA_CICLOS    = 8,
    localparam int ZW = ($clog2(ZONAS) > 1) ? $clog2(ZONAS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             habilita,
    input  logic             umidadeAr,
    input  logic             temperatura,
    input  logic [ZONAS-1:0] umidadeSolo,
    input  logic             high,
    input  logic             mediun,
    input  logic             low,
    output logic [ZONAS-1:0] gotejamento,
    output logic [ZONAS-1:0] aspersao,
    output logic             valvulaEntrada,
    output logic             erro,
    output logic             alarme,
    output logic [ZW-1:0]    zonaAtiva,
    output logic             ocupado,
    output logic [7:0]       regasConcluidas
);

    localparam int DW   = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam int TMAX = (TEMPO_REGA > PAUSA_CICLOS) ? TEMPO_REGA : PAUSA_CICLOS;
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [ZW-1:0] ULTIMA = ZW'(ZONAS - 1);

    typedef enum logic [1:0] {IDLE, AVALIA, REGA, PAUSA} estado_t;

    logic [2:0]    bruto;
    logic [2:0]    filt_q;
    logic [DW-1:0] deb_q [3];
    logic          hF, mF, lF, critico;

    estado_t       estado_q, estado_d;
    logic [ZW-1:0] zona_q, zona_d, zonaProx;
    logic          modo_q, modo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    regas_q, regas_d;
    logic          valv_q, valv_d;
    logic          abortar;

    assign bruto = {high, mediun, low};
    assign hF    = filt_q[2];
    assign mF    = filt_q[1];
    assign lF    = filt_q[0];

    // A filtered level only follows its raw sensor after an unbroken run of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < 3; i++) deb_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (bruto[i] == filt_q[i]) begin
                    deb_q[i] <= '0;
                end else if (deb_q[i] == DW'(DEBOUNCE_CICLOS - 1)) begin
                    filt_q[i] <= bruto[i];
                    deb_q[i]  <= '0;
                end else begin
                    deb_q[i] <= deb_q[i] + 1'b1;
                end
            end
        end
    end

    assign critico = ~lF;
    assign erro    = (hF & ~mF) | (mF & ~lF);
    assign alarme  = erro | critico;

    // Between the medium and high marks the inlet keeps whatever it was doing.
    always_comb begin
        valv_d = valv_q;
        if (erro)     valv_d = 1'b0;
        else if (hF)  valv_d = 1'b0;
        else if (!mF) valv_d = 1'b1;
    end

    assign zonaProx = (zona_q == ULTIMA) ? '0 : zona_q + 1'b1;
    assign abortar  = alarme | umidadeSolo[zona_q] | ~habilita;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            zona_q   <= '0;
            modo_q   <= 1'b0;
            cnt_q    <= '0;
            regas_q  <= '0;
            valv_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            zona_q   <= zona_d;
            modo_q   <= modo_d;
            cnt_q    <= cnt_d;
            regas_q  <= regas_d;
            valv_q   <= valv_d;
        end
    end

    // An aborted burst still gets its full pause but is not counted as completed.
    always_comb begin
        estado_d = estado_q;
        zona_d   = zona_q;
        modo_d   = modo_q;
        cnt_d    = cnt_q;
        regas_d  = regas_q;
        case (estado_q)
            IDLE: begin
                if (habilita && !alarme) estado_d = AVALIA;
            end
            AVALIA: begin
                if (!umidadeSolo[zona_q] && !alarme) begin
                    modo_d   = (mF & ~temperatura) | ~umidadeAr;
                    cnt_d    = '0;
                    estado_d = REGA;
                end else begin
                    zona_d   = zonaProx;
                    estado_d = IDLE;
                end
            end
            REGA: begin
                if (abortar) begin
                    cnt_d    = '0;
                    estado_d = PAUSA;
                end else if (cnt_q == CW'(TEMPO_REGA - 1)) begin
                    cnt_d    = '0;
                    estado_d = PAUSA;
                    if (regas_q != 8'hFF) regas_d = regas_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PAUSA: begin
                if (cnt_q == CW'(PAUSA_CICLOS - 1)) begin
                    cnt_d    = '0;
                    zona_d   = zonaProx;
                    estado_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_comb begin
        gotejamento = '0;
        aspersao    = '0;
        if (estado_q == REGA) begin
            if (modo_q) aspersao[zona_q]    = 1'b1;
            else        gotejamento[zona_q] = 1'b1;
        end
    end

    assign ocupado         = (estado_q == REGA) || (estado_q == PAUSA);
    assign zonaAtiva       = zona_q;
    assign valvulaEntrada  = valv_q;
    assign regasConcluidas = regas_q;

endmodule

// File: tb/tb_irrigacao_multizona.sv
// Bench for irrigacao_multizona: directed scenarios plus random traffic, checked every
// cycle against a behavioural model of the tank, inlet valve and watering schedule.
module tb_irrigacao_multizona;

    localparam int ZONAS = 4;
    localparam int DEB   = 4;
    localparam int TREGA = 16;
    localparam int TPAUS = 8;
    localparam int ZW    = 2;

    localparam int FIDLE   = 0;
    localparam int FAVALIA = 1;
    localparam int FREGA   = 2;
    localparam int FPAUSA  = 3;

    logic             clk;
    logic             rst_n;
    logic             habilita, umidadeAr, temperatura;
    logic [ZONAS-1:0] umidadeSolo;
    logic             high, mediun, low;
    logic [ZONAS-1:0] gotejamento, aspersao;
    logic             valvulaEntrada, erro, alarme, ocupado;
    logic [ZW-1:0]    zonaAtiva;
    logic [7:0]       regasConcluidas;

    int checks = 0;
    int errors = 0;

    // Model state: filtered levels (0 high, 1 mediun, 2 low) with raw history, schedule.
    bit        fM [3];
    bit [31:0] histM [3];
    bit        valvM;
    int        fase, zonaM, restante, regasM;
    bit        sprinkler;

    irrigacao_multizona #(
        .ZONAS(ZONAS), .DEBOUNCE_CICLOS(DEB), .TEMPO_REGA(TREGA), .PAUSA_CICLOS(TPAUS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .habilita(habilita), .umidadeAr(umidadeAr),
        .temperatura(temperatura), .umidadeSolo(umidadeSolo), .high(high),
        .mediun(mediun), .low(low), .gotejamento(gotejamento), .aspersao(aspersao),
        .valvulaEntrada(valvulaEntrada), .erro(erro), .alarme(alarme),
        .zonaAtiva(zonaAtiva), .ocupado(ocupado), .regasConcluidas(regasConcluidas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string campo, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s/%s observed=%0h expected=%0h", tag, campo, obs, exp);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 3; i++) begin
            fM[i]    = 1'b0;
            histM[i] = '0;
        end
        valvM     = 1'b0;
        fase      = FIDLE;
        zonaM     = 0;
        restante  = 0;
        regasM    = 0;
        sprinkler = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic stepModel();
        bit rawS [3];
        bit h, m, l, er, al, estavel;
        rawS[0] = high;
        rawS[1] = mediun;
        rawS[2] = low;
        h  = fM[0];
        m  = fM[1];
        l  = fM[2];
        er = (h && !m) || (m && !l);
        al = er || !l;
        if (er)      valvM = 1'b0;
        else if (h)  valvM = 1'b0;
        else if (!m) valvM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            histM[i] = {histM[i][30:0], rawS[i]};
            estavel = 1'b1;
            for (int k = 0; k < DEB; k++)
                if (histM[i][k] == fM[i]) estavel = 1'b0;
            if (estavel) fM[i] = rawS[i];
        end
        case (fase)
            FIDLE: if (habilita && !al) fase = FAVALIA;
            FAVALIA: begin
                if (!umidadeSolo[zonaM] && !al) begin
                    sprinkler = (m && !temperatura) || !umidadeAr;
                    restante  = TREGA;
                    fase      = FREGA;
                end else begin
                    zonaM = (zonaM + 1) % ZONAS;
                    fase  = FIDLE;
                end
            end
            FREGA: begin
                if (al || umidadeSolo[zonaM] || !habilita) begin
                    fase     = FPAUSA;
                    restante = TPAUS;
                end else if (restante == 1) begin
                    regasM   = (regasM < 255) ? regasM + 1 : 255;
                    fase     = FPAUSA;
                    restante = TPAUS;
                end else begin
                    restante--;
                end
            end
            default: begin
                if (restante == 1) begin
                    zonaM = (zonaM + 1) % ZONAS;
                    fase  = FIDLE;
                end else begin
                    restante--;
                end
            end
        endcase
    endtask

    task automatic checkOutput(input string tag);
        logic [ZONAS-1:0] eg, ea;
        bit er;
        eg = '0;
        ea = '0;
        if (fase == FREGA) begin
            if (sprinkler) ea[zonaM] = 1'b1;
            else           eg[zonaM] = 1'b1;
        end
        er = (fM[0] && !fM[1]) || (fM[1] && !fM[2]);
        chk(tag, "gotejamento", 32'(gotejamento), 32'(eg));
        chk(tag, "aspersao", 32'(aspersao), 32'(ea));
        chk(tag, "valvulaEntrada", 32'(valvulaEntrada), 32'(valvM));
        chk(tag, "erro", 32'(erro), 32'(er));
        chk(tag, "alarme", 32'(alarme), 32'(er || !fM[2]));
        chk(tag, "zonaAtiva", 32'(zonaAtiva), 32'(zonaM));
        chk(tag, "ocupado", 32'(ocupado), 32'(fase == FREGA || fase == FPAUSA));
        chk(tag, "regasConcluidas", 32'(regasConcluidas), 32'(regasM));
    endtask

    task automatic applyStimulus(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            stepModel();
            #1;
            checkOutput(tag);
        end
    endtask

    initial begin
        int nGot;
        logic [2:0] nivel, glitch;
        int glitchLeft;

        rst_n = 1'b1;
        {habilita, umidadeAr, temperatura, high, mediun, low} = '0;
        umidadeSolo = '0;
        resetModel();
        #1 rst_n = 1'b0;
        #2 checkOutput("reset");
        chk("reset", "alarmeInicial", 32'(alarme), 32'd1);
        #4 rst_n = 1'b1;

        {high, mediun, low} = 3'b111;
        applyStimulus(3, "enche");
        chk("enche", "alarmeAntes", 32'(alarme), 32'd1);
        applyStimulus(3, "enche");
        chk("enche", "alarmeDepois", 32'(alarme), 32'd0);
        chk("enche", "valvulaCheio", 32'(valvulaEntrada), 32'd0);

        habilita    = 1'b1;
        umidadeSolo = 4'b1011;
        umidadeAr   = 1'b1;
        temperatura = 1'b1;
        nGot = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1, "zona2");
            if (gotejamento === 4'b0100) nGot++;
        end
        chk("zona2", "ciclosGotejo", 32'(nGot), 32'd16);
        chk("zona2", "regas", 32'(regasConcluidas), 32'd1);
        chk("zona2", "zonaFinal", 32'(zonaAtiva), 32'd3);
        habilita = 1'b0;
        applyStimulus(2, "zona2");

        nivel = 3'b111;
        glitch = '0;
        glitchLeft = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) umidadeSolo = 4'($urandom);
            habilita = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 15) == 0) umidadeAr = 1'($urandom);
            if ($urandom_range(0, 15) == 0) temperatura = 1'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 5))
                    0: nivel = 3'b000;
                    1: nivel = 3'b001;
                    2: nivel = 3'b011;
                    3: nivel = 3'b101;
                    default: nivel = 3'b111;
                endcase
            end
            if (glitchLeft == 0 && $urandom_range(0, 24) == 0) begin
                glitch = 3'b001 << $urandom_range(0, 2);
                glitchLeft = $urandom_range(1, DEB + 1);
            end
            if (glitchLeft > 0) glitchLeft--;
            else glitch = '0;
            {high, mediun, low} = nivel ^ glitch;
            applyStimulus(1, "aleatorio");
        end

        rst_n = 1'b0;
        resetModel();
        #1 checkOutput("reset2");
        #1 rst_n = 1'b1;
        {high, mediun, low} = 3'b011;
        umidadeAr   = 1'b1;
        temperatura = 1'b0;
        umidadeSolo = 4'b1110;
        habilita    = 1'b1;
        applyStimulus(10, "aspersao");
        chk("aspersao", "aspersao0", 32'(aspersao), 32'b0001);
        chk("aspersao", "valvulaMantida", 32'(valvulaEntrada), 32'd1);
        low = 1'b0;
        applyStimulus(6, "critico");
        chk("critico", "aspersaoOff", 32'(aspersao), 32'd0);
        chk("critico", "regasInalteradas", 32'(regasConcluidas), 32'd0);
        applyStimulus(20, "critico");
        chk("critico", "semNovaRega", 32'(aspersao | gotejamento), 32'd0);

        habilita = 1'b0;
        {high, mediun, low} = 3'b111;
        applyStimulus(6, "drena");
        high = 1'b0;
        applyStimulus(6, "drena");
        mediun = 1'b0;
        applyStimulus(3, "drena");
        chk("drena", "valvulaAntes", 32'(valvulaEntrada), 32'd0);
        applyStimulus(3, "drena");
        chk("drena", "valvulaAberta", 32'(valvulaEntrada), 32'd1);
        mediun = 1'b1;
        applyStimulus(6, "reenche");
        mediun = 1'b0;
        applyStimulus(2, "glitch");
        mediun = 1'b1;
        applyStimulus(6, "glitch");
        chk("glitch", "valvulaAberta", 32'(valvulaEntrada), 32'd1);
        high = 1'b1;
        applyStimulus(6, "cheio");
        chk("cheio", "valvulaFechada", 32'(valvulaEntrada), 32'd0);

        mediun = 1'b0;
        applyStimulus(6, "inconsistente");
        chk("inconsistente", "erro", 32'(erro), 32'd1);
        chk("inconsistente", "alarme", 32'(alarme), 32'd1);
        chk("inconsistente", "valvula", 32'(valvulaEntrada), 32'd0);

        mediun      = 1'b1;
        habilita    = 1'b1;
        umidadeSolo = 4'b0000;
        applyStimulus(12, "preReset");
        chk("preReset", "ocupado", 32'(ocupado), 32'd1);
        chk("preReset", "valvulas", 32'(gotejamento | aspersao) != 0 ? 32'd1 : 32'd0, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("resetAssinc", "valvulas", 32'(gotejamento | aspersao), 32'd0);
        chk("resetAssinc", "ocupado", 32'(ocupado), 32'd0);
        resetModel();
        checkOutput("resetAssinc");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8, "posReset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
